uart_tx_feeder: RTL

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder.sv | 100 ++++++++++
 1 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter one frame at a time, gated by remote cts_n.
// Pop, start_tx and tx_data update on the same edge as the launch; wr_ready falls only when full.
module uart_tx_feeder #(
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_valid,
   input  logic [7:0]                   wr_data,
   output logic                         wr_ready,
   input  logic                         cts_n,
   input  logic                         tx_done,
   output logic                         start_tx,
   output logic [7:0]                   tx_data,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
   output logic                         busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   typedef enum logic {IDLE, WAIT_DONE} state_t;

   state_t          state_q;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            start_q;
   logic            busy_q;
   logic [7:0]      data_q;
   logic [7:0]      mem_q [DEPTH];
   logic            push;
   logic            pop;

   // A full FIFO refuses pushes even when a pop frees a slot on the same edge.
   assign wr_ready = (count_q != CW'(DEPTH));
   assign push     = wr_valid && wr_ready;
   assign pop      = (state_q == IDLE) && (count_q != '0) && !cts_n;

   // DEPTH is a power of two, so pointer overflow wraps DEPTH-1 back to 0.
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // tx_done is only honoured in WAIT_DONE; the return to IDLE forces a gap before the next launch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pop) begin
                  data_q  <= mem_q[rd_ptr_q];
                  start_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (tx_done) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign start_tx   = start_q;
   assign tx_data    = data_q;
   assign fifo_count = count_q;
   assign busy       = busy_q;
endmodule
